sht1x_convert: RTL and testbench
================================

# sht1x_convert

Downstream consumer of the SHT1x bus controller. Accepts raw 14-bit temperature and 12-bit humidity words over a valid/ready handshake, optionally checks the sensor CRC-8, converts the words to signed centi-degrees Celsius and clamped centi-percent RH, and exposes the results on an Avalon-MM slave. Humidity conversion uses a multi-cycle shift-add multiplier, so the block has a fixed, documented latency.

## Interface
- No parameters.
- `rsi_MRST_reset` in 1: reset, asynchronous, active-high.
- `csi_MCLK_clk` in 1: clock.
- `raw_valid` in 1: raw sample present.
- `raw_ready` out 1: block can accept a sample.
- `raw_kind` in 1: sample type, 0 = temperature, 1 = humidity.
- `raw_data` in 16: raw sensor word. Temperature uses bits [13:0]; humidity uses bits [11:0].
- `raw_crc` in 8: CRC byte as received from the sensor.
- `avs_ctrl_address` in 3, `avs_ctrl_read` in 1, `avs_ctrl_write` in 1, `avs_ctrl_writedata` in 32, `avs_ctrl_byteenable` in 4: Avalon-MM slave inputs.
- `avs_ctrl_readdata` out 32: read data.
- `avs_ctrl_waitrequest` out 1: tied to 0.

## Operation
- FSM states: IDLE, TEMP, SQR, LIN, SUM, CLAMP.
- `raw_ready` is 1 only in IDLE. A sample is accepted on an edge where `raw_valid` and `raw_ready` are both 1; `raw_kind`, `raw_data` and `raw_crc` are latched on that edge.
- After accept, the FSM goes to TEMP if kind is 0, and to SQR if kind is 1.
- TEMP (1 cycle): `t = {2'b0, SO[13:0]} - 4010`, as a 16-bit signed value. Load `t_reg`, then return to IDLE.
- SQR (12 cycles): shift-add computation of `SO*SO` (24 bits), with SO = `raw_data[11:0]`.
- LIN (12 cycles): shift-add computation of `61572383*SO`.
- SUM (1 cycle): 40-bit signed accumulator `acc = 61572383*SO - 2677*SO*SO - 3433940582`.
- CLAMP (1 cycle):
  - `r = acc >>> 24`.
  - If `r < 0`, `rh_reg = 0`; if `r > 10000`, `rh_reg = 10000`; otherwise `rh_reg = r[15:0]`.
  - Return to IDLE.
- Status counter: on each result load, `cnt` (8 bits, wraps 255 → 0) increments, and `t_valid` or `rh_valid` is set.
- Register map (readdata is registered and valid the cycle after the read strobe, as in the rest of the Qsys family):
  - 0: ID 0xEA680004.
  - 1: `t_reg`, sign-extended to 32 bits.
  - 2: `{16'd0, rh_reg}`.
  - 3: `{16'd0, cnt, 5'd0, crc_err, rh_valid, t_valid}`.
  - 4–7: read 0.
- Reading address 3 clears `t_valid` and `rh_valid`.
- Writing address 3 with `writedata[2]` = 1 clears `crc_err`.
- Writes are ignored at all other addresses. Only byteenable[0] is honoured.
- Simultaneous events: a result load on the same edge as a status read leaves the corresponding valid bit set (load wins).
- Reset values: `raw_ready` 0 during reset and 1 on the first edge after release; `avs_ctrl_readdata` 0; `t_reg`, `rh_reg`, `cnt`, `crc_err`, `t_valid`, `rh_valid` all 0; FSM in IDLE.
- Reset asserted mid-conversion aborts the conversion and discards the partial result.

## Timing
- Accept edge is N.
- Temperature: result is visible in `t_reg` after edge N+1.
- Humidity: result is visible in `rh_reg` after edge N+26 (12 SQR + 12 LIN + SUM + CLAMP).
- `raw_ready` returns to 1 in the cycle after the final load.
- Back-to-back throughput: 1 sample per 2 cycles for temperature, 1 sample per 27 cycles for humidity.
- Bus read latency is 1 cycle. `waitrequest` is never asserted.

## Configuration
- Macro: `SHT1X_CRC_CHECK_EN`.
- When defined:
  - A serial CRC-8 is run during the conversion cycles. Polynomial 0x31, initial value 0x00, MSB first, over the command byte (0x03 for temperature, 0x05 for humidity), then `raw_data[15:8]`, then `raw_data[7:0]`.
  - The result is compared against `raw_crc` bit-reversed.
  - On mismatch: `crc_err` is set, the result registers, valid bits and `cnt` are left unchanged, and the latency is unchanged.
- When undefined: `raw_crc` is ignored, every sample updates the result registers, and `crc_err` reads 0.

## Test plan
- Reset → address 0 reads 0xEA680004; addresses 1–3 read 0; `raw_ready` is 1 after release.
- Temperature raw 6500 → address 1 reads 2490 at N+1 and address 3 reads 0x00000101. Raw 0 → address 1 reads 0xFFFFF056. Raw 16383 → address 1 reads 12373.
- Humidity raw 1000 → address 2 reads 3305 exactly 26 cycles after accept. Raw 0 → 0 (clamped). Raw 4095 → 10000 (clamped). `raw_ready` stays 0 throughout each conversion.
- Read of address 3 on the same edge as a temperature load → `t_valid` stays 1. A second read → `t_valid` is 0. 256 samples → `cnt` wraps to 0.
- Reset pulsed at cycle 10 of a humidity conversion → `rh_reg` is 0, FSM is in IDLE, and the next sample converts correctly.
- With `SHT1X_CRC_CHECK_EN` defined, a corrupted CRC → `crc_err` = 1 and results are unchanged. Writing 0x4 to address 3 clears `crc_err`. The correct CRC from the reference model updates the results.

Source files
------------

// File: rtl/sht1x_convert_if.sv
// Raw-sample handshake and Avalon-MM control bus for the SHT1x result converter.
// The master side is the bus controller / CPU fabric; the slave side is sht1x_convert.
interface sht1x_convert_if;
    logic        raw_valid;
    logic        raw_ready;
    logic        raw_kind;
    logic [15:0] raw_data;
    logic [7:0]  raw_crc;

    logic [2:0]  avs_ctrl_address;
    logic        avs_ctrl_read;
    logic        avs_ctrl_write;
    logic [31:0] avs_ctrl_writedata;
    logic [3:0]  avs_ctrl_byteenable;
    logic [31:0] avs_ctrl_readdata;
    logic        avs_ctrl_waitrequest;

    modport master (
        output raw_valid, raw_kind, raw_data, raw_crc,
        output avs_ctrl_address, avs_ctrl_read, avs_ctrl_write,
        output avs_ctrl_writedata, avs_ctrl_byteenable,
        input  raw_ready, avs_ctrl_readdata, avs_ctrl_waitrequest
    );

    modport slave (
        input  raw_valid, raw_kind, raw_data, raw_crc,
        input  avs_ctrl_address, avs_ctrl_read, avs_ctrl_write,
        input  avs_ctrl_writedata, avs_ctrl_byteenable,
        output raw_ready, avs_ctrl_readdata, avs_ctrl_waitrequest
    );
endinterface

// File: rtl/sht1x_convert.sv
// Converts raw SHT1x temperature/humidity words to centi-units and exposes them on Avalon-MM.
// Optional sensor CRC-8 checking is enabled by defining SHT1X_CRC_CHECK_EN.
module sht1x_convert (
    input  logic           csi_MCLK_clk,
    input  logic           rsi_MRST_reset,
    sht1x_convert_if.slave bus
);

    localparam logic [31:0]        ID_WORD   = 32'hEA68_0004;
    localparam logic [15:0]        T_OFFSET  = 16'd4010;
    localparam logic [25:0]        LIN_COEF  = 26'd61572383;
    localparam logic [35:0]        SQ_COEF   = 36'd2677;
    localparam logic signed [39:0] RH_OFFSET = 40'sd3433940582;
    localparam logic signed [15:0] RH_MAX    = 16'sd10000;

    typedef enum logic [2:0] {IDLE, TEMP, SQR, LIN, SUM, CLAMP} state_t;

    state_t state, next_state;
    logic   ready_q;
    logic [3:0] bit_idx;

    logic raw_ready_c, accept, sq_step, lin_step, sum_step, load_t, load_rh, last_bit;

    logic        kind_q;
    logic [15:0] data_q;
    logic [11:0] so;
    logic [23:0] sq_acc;
    logic [37:0] lin_acc;
    logic [35:0] sq_term;
    logic signed [39:0] sum_acc;
    logic signed [15:0] rh_r;
    logic [15:0] t_value, rh_value;

    logic [15:0] t_reg, rh_reg;
    logic [7:0]  cnt;
    logic        t_valid, rh_valid, crc_err;
    logic [31:0] readdata_q, rd_mux;
    logic        crc_ok, status_rd, crc_clr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            bit_idx <= 4'd0;
        end else begin
            state   <= next_state;
            ready_q <= 1'b1;
            bit_idx <= ((sq_step || lin_step) && !last_bit) ? bit_idx + 4'd1 : 4'd0;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: combinational blocks use blocking '=' so later lines see earlier results; flops use '<='.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = bus.raw_kind ? SQR : TEMP;
            TEMP:    next_state = IDLE;
            SQR:     if (last_bit) next_state = LIN;
            LIN:     if (last_bit) next_state = SUM;
            SUM:     next_state = CLAMP;
            CLAMP:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        raw_ready_c = 1'b0;
        sq_step     = 1'b0;
        lin_step    = 1'b0;
        sum_step    = 1'b0;
        load_t      = 1'b0;
        load_rh     = 1'b0;
        case (state)
            IDLE:    raw_ready_c = ready_q;
            TEMP:    load_t      = 1'b1;
            SQR:     sq_step     = 1'b1;
            LIN:     lin_step    = 1'b1;
            SUM:     sum_step    = 1'b1;
            CLAMP:   load_rh     = 1'b1;
            default: raw_ready_c = 1'b0;
        endcase
    end

    assign accept   = raw_ready_c && bus.raw_valid;
    assign last_bit = (bit_idx == 4'd11);
    assign bus.raw_ready = raw_ready_c;

    // ---------------- datapath ----------------
    assign so      = data_q[11:0];
    assign sq_term = 36'(sq_acc) * SQ_COEF;

    // NOTE: datapath registers carry no reset; the FSM never consumes them before an accept loads them.
    always_ff @(posedge csi_MCLK_clk) begin
        if (accept) begin
            kind_q  <= bus.raw_kind;
            data_q  <= bus.raw_data;
            sq_acc  <= 24'd0;
            lin_acc <= 38'd0;
        end
        if (sq_step && so[bit_idx])
            sq_acc <= sq_acc + (24'(so) << bit_idx);
        if (lin_step && so[bit_idx])
            lin_acc <= lin_acc + (38'(LIN_COEF) << bit_idx);
        if (sum_step)
            sum_acc <= $signed({2'b00, lin_acc}) - $signed({4'b0000, sq_term}) - RH_OFFSET;
    end

    assign t_value = {2'b00, data_q[13:0]} - T_OFFSET;
    assign rh_r    = sum_acc[39:24];

    always_comb begin
        if (rh_r < 16'sd0)
            rh_value = 16'd0;
        else if (rh_r > RH_MAX)
            rh_value = 16'd10000;
        else
            rh_value = rh_r;
    end

`ifdef SHT1X_CRC_CHECK_EN
    logic [7:0] crc_q;

    always_ff @(posedge csi_MCLK_clk) begin
        if (accept) crc_q <= bus.raw_crc;
    end

    // Bit-serial CRC-8 (poly 0x31, init 0) unrolled over command byte plus data word.
    function automatic logic [7:0] crc8_msb(input logic [23:0] msg);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb  = crc[7] ^ msg[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
        end
        return crc;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // The sensor ships its CRC LSB-first, so the received byte is compared reversed.
    assign crc_ok = (crc8_msb({kind_q ? 8'h05 : 8'h03, data_q}) == rev8(crc_q));

    logic unused_bits;
    assign unused_bits = ^{sum_acc[23:0], bus.avs_ctrl_writedata[31:3],
                           bus.avs_ctrl_writedata[1:0], bus.avs_ctrl_byteenable[3:1]};
`else
    assign crc_ok = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{kind_q, data_q[15:14], bus.raw_crc, sum_acc[23:0],
                           bus.avs_ctrl_writedata[31:3], bus.avs_ctrl_writedata[1:0],
                           bus.avs_ctrl_byteenable[3:1]};
`endif

    // ---------------- register file ----------------
    assign status_rd = bus.avs_ctrl_read && (bus.avs_ctrl_address == 3'd3);
    assign crc_clr   = bus.avs_ctrl_write && (bus.avs_ctrl_address == 3'd3) &&
                       bus.avs_ctrl_byteenable[0] && bus.avs_ctrl_writedata[2];

    always_comb begin
        rd_mux = 32'd0;
        case (bus.avs_ctrl_address)
            3'd0:    rd_mux = ID_WORD;
            3'd1:    rd_mux = {{16{t_reg[15]}}, t_reg};
            3'd2:    rd_mux = {16'd0, rh_reg};
            3'd3:    rd_mux = {16'd0, cnt, 5'd0, crc_err, rh_valid, t_valid};
            default: rd_mux = 32'd0;
        endcase
    end

    // Later assignments win: a result load overrides a same-edge status-read clear.
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            readdata_q <= 32'd0;
            t_reg      <= 16'd0;
            rh_reg     <= 16'd0;
            cnt        <= 8'd0;
            t_valid    <= 1'b0;
            rh_valid   <= 1'b0;
            crc_err    <= 1'b0;
        end else begin
            if (bus.avs_ctrl_read) readdata_q <= rd_mux;
            if (status_rd) begin
                t_valid  <= 1'b0;
                rh_valid <= 1'b0;
            end
            if (crc_clr) crc_err <= 1'b0;
            if (load_t || load_rh) begin
                if (crc_ok) begin
                    cnt <= cnt + 8'd1;
                    if (load_t) begin
                        t_reg   <= t_value;
                        t_valid <= 1'b1;
                    end else begin
                        rh_reg   <= rh_value;
                        rh_valid <= 1'b1;
                    end
                end else begin
                    crc_err <= 1'b1;
                end
            end
        end
    end

    assign bus.avs_ctrl_readdata    = readdata_q;
    assign bus.avs_ctrl_waitrequest = 1'b0;

endmodule

// File: tb/tb_sht1x_convert.sv
// Scoreboard bench for sht1x_convert: stimulus pushes expected read data, a monitor pops and compares.
// Reference model works from the conversion formulas with plain integer arithmetic.
module tb_sht1x_convert;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sht1x_convert_if bus ();

    sht1x_convert dut (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .bus            (bus)
    );

`ifdef SHT1X_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_cmp  = 0;
    int      n_fail = 0;
    logic    rd_seen;

    // reference model state
    int m_t, m_rh, m_cnt, m_loads;
    bit m_tv, m_rv, m_crc_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) rd_seen <= 1'b0;
        else     rd_seen <= bus.avs_ctrl_read;
    end

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_seen) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: readdata 0x%08h with nothing expected", bus.avs_ctrl_readdata);
            end else begin
                e = sb.pop_front();
                check(e.name, bus.avs_ctrl_readdata, e.exp);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] crc_ref(input bit kind, input logic [15:0] data);
        logic [31:0] rem;
        rem = {kind ? 8'h05 : 8'h03, data, 8'h00};
        for (int i = 31; i >= 8; i--)
            if (rem[i]) rem = rem ^ (32'h131 << (i - 8));
        return rem[7:0];
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        return {<<{v}};
    endfunction

    function automatic logic [7:0] good_crc(input bit kind, input logic [15:0] data);
        if (CRC_EN) return rev8(crc_ref(kind, data));
        return 8'($urandom);
    endfunction

    function automatic int rh_ref(input logic [11:0] raw);
        longint s, acc, r;
        s   = longint'(raw);
        acc = 61572383 * s - 2677 * s * s - 64'sd3433940582;
        r   = acc >>> 24;
        if (r < 0)     return 0;
        if (r > 10000) return 10000;
        return int'(r);
    endfunction

    function automatic logic [31:0] status_word();
        return {16'd0, 8'(m_cnt), 5'd0, m_crc_err, m_rv, m_tv};
    endfunction

    task automatic model_reset();
        m_t = 0; m_rh = 0; m_cnt = 0; m_loads = 0;
        m_tv = 0; m_rv = 0; m_crc_err = 0;
    endtask

    task automatic model_load(input bit kind, input logic [15:0] data, input logic [7:0] crc);
        bit ok;
        ok = !CRC_EN || (crc == rev8(crc_ref(kind, data)));
        if (!ok) begin
            m_crc_err = 1;
        end else begin
            m_cnt = (m_cnt + 1) % 256;
            m_loads++;
            if (kind) begin
                m_rh = rh_ref(data[11:0]);
                m_rv = 1;
            end else begin
                m_t  = int'(data[13:0]) - 4010;
                m_tv = 1;
            end
        end
    endtask

    // ---------------- bus and sample drivers (called at a falling edge) ----------------
    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
        bus.avs_ctrl_address = addr;
        bus.avs_ctrl_read    = 1'b1;
        sb.push_back('{exp: exp, name: name});
        @(negedge clk);
        bus.avs_ctrl_read    = 1'b0;
    endtask

    task automatic read_status(input string name);
        bus_read(3'd3, status_word(), name);
        m_tv = 0;
        m_rv = 0;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.avs_ctrl_address    = addr;
        bus.avs_ctrl_writedata  = data;
        bus.avs_ctrl_byteenable = be;
        bus.avs_ctrl_write      = 1'b1;
        @(negedge clk);
        bus.avs_ctrl_write      = 1'b0;
        if (addr == 3'd3 && be[0] && data[2]) m_crc_err = 0;
    endtask

    task automatic accept_only(input bit kind, input logic [15:0] data, input logic [7:0] crc);
        int guard;
        guard = 0;
        while (bus.raw_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) check("ready_timeout", 32'(bus.raw_ready), 32'd1);
        bus.raw_valid = 1'b1;
        bus.raw_kind  = kind;
        bus.raw_data  = data;
        bus.raw_crc   = crc;
        @(negedge clk);
        bus.raw_valid = 1'b0;
    endtask

    task automatic send(input bit kind, input logic [15:0] data, input logic [7:0] crc);
        int busy;
        accept_only(kind, data, crc);
        busy = 0;
        while (bus.raw_ready !== 1'b1 && busy < 64) begin
            busy++;
            @(negedge clk);
        end
        check(kind ? "rh_busy_cycles" : "t_busy_cycles", 32'(busy), kind ? 32'd26 : 32'd1);
        model_load(kind, data, crc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         busy_bad;
        bit         kind;
        logic [15:0] data;
        logic [7:0]  crc;

        bus.raw_valid = 1'b0; bus.raw_kind = 1'b0; bus.raw_data = 16'd0; bus.raw_crc = 8'd0;
        bus.avs_ctrl_address = 3'd0; bus.avs_ctrl_read = 1'b0; bus.avs_ctrl_write = 1'b0;
        bus.avs_ctrl_writedata = 32'd0; bus.avs_ctrl_byteenable = 4'h0;
        model_reset();

        // reset state
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(bus.raw_ready), 32'd0);
        check("readdata_in_reset", bus.avs_ctrl_readdata, 32'd0);
        check("waitrequest", 32'(bus.avs_ctrl_waitrequest), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(bus.raw_ready), 32'd1);
        bus_read(3'd0, 32'hEA68_0004, "id");
        bus_read(3'd1, 32'd0, "t_reset");
        bus_read(3'd2, 32'd0, "rh_reset");
        read_status("status_reset");
        bus_read(3'd5, 32'd0, "addr5");
        bus_read(3'd7, 32'd0, "addr7");

        // temperature 6500 with a status read landing on the load edge
        data = 16'd6500;
        accept_only(1'b0, data, good_crc(1'b0, data));
        bus_read(3'd3, 32'h0000_0000, "status_on_load_edge");
        m_tv = 0; m_rv = 0;
        model_load(1'b0, data, rev8(crc_ref(1'b0, data)));
        check("ready_after_t_load", 32'(bus.raw_ready), 32'd1);
        bus_read(3'd1, 32'd2490, "t_6500");
        bus_read(3'd3, 32'h0000_0101, "status_load_wins");
        m_tv = 0; m_rv = 0;
        bus_read(3'd3, 32'h0000_0100, "status_cleared");

        send(1'b0, 16'd0, good_crc(1'b0, 16'd0));
        bus_read(3'd1, 32'hFFFF_F056, "t_0");
        send(1'b0, 16'd16383, good_crc(1'b0, 16'd16383));
        bus_read(3'd1, 32'd12373, "t_16383");

        // humidity 1000: old value at edge N+26, new value right after it
        data = 16'd1000;
        crc  = good_crc(1'b1, data);
        accept_only(1'b1, data, crc);
        busy_bad = 0;
        repeat (25) begin
            if (bus.raw_ready !== 1'b0) busy_bad++;
            @(negedge clk);
        end
        check("rh_ready_low", 32'(busy_bad), 32'd0);
        check("rh_ready_low_last", 32'(bus.raw_ready), 32'd0);
        bus_read(3'd2, 32'd0, "rh_before_load");
        model_load(1'b1, data, crc);
        check("ready_after_rh_load", 32'(bus.raw_ready), 32'd1);
        bus_read(3'd2, 32'd3305, "rh_1000");

        send(1'b1, 16'd0, good_crc(1'b1, 16'd0));
        bus_read(3'd2, 32'd0, "rh_0_clamp");
        send(1'b1, 16'd4095, good_crc(1'b1, 16'd4095));
        bus_read(3'd2, 32'd10000, "rh_4095_clamp");

        // writes elsewhere are ignored
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd2, 32'h0000_1234, 4'hF);
        bus_read(3'd1, 32'd12373, "t_after_write");
        bus_read(3'd2, 32'd10000, "rh_after_write");
        bus_write(3'd3, 32'hFFFF_FFFF, 4'hF);
        read_status("status_after_write");

`ifdef SHT1X_CRC_CHECK_EN
        // corrupted CRC: error flagged, results untouched
        data = 16'd6500;
        send(1'b0, data, good_crc(1'b0, data) ^ 8'h01);
        read_status("status_crc_err");
        bus_read(3'd1, 32'd12373, "t_after_bad_crc");
        bus_write(3'd3, 32'h0000_0004, 4'b1110);
        read_status("crc_err_be_masked");
        bus_write(3'd3, 32'h0000_0004, 4'b0001);
        read_status("crc_err_cleared");
        send(0, data, good_crc(1'b0, data));
        bus_read(3'd1, 32'd2490, "t_after_good_crc");
`endif

        // reset pulsed ten cycles into a humidity conversion
        data = 16'd2000;
        accept_only(1'b1, data, good_crc(1'b1, data));
        repeat (9) @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check("ready_in_mid_reset", 32'(bus.raw_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", 32'(bus.raw_ready), 32'd1);
        bus_read(3'd2, 32'd0, "rh_after_abort");
        bus_read(3'd1, 32'd0, "t_after_abort");
        read_status("status_after_abort");
        send(1'b1, 16'd1000, good_crc(1'b1, 16'd1000));
        bus_read(3'd2, 32'd3305, "rh_after_abort_conv");

        // randomized samples until the load counter has wrapped
        for (int i = 0; i < 800 && m_loads < 256; i++) begin
            kind = ($urandom_range(0, 7) == 0);
            data = 16'($urandom);
            crc  = good_crc(kind, data);
            if (CRC_EN && $urandom_range(0, 15) == 0) crc = crc ^ 8'h80;
            send(kind, data, crc);
            if (kind) bus_read(3'd2, 32'(m_rh), "rh_random");
            else      bus_read(3'd1, 32'(m_t), "t_random");
            if (i % 16 == 0) read_status("status_random");
            if (m_crc_err && $urandom_range(0, 3) == 0) bus_write(3'd3, 32'h4, 4'h1);
        end
        check("loads_reached", 32'(m_loads), 32'd256);
        read_status("status_cnt_wrap");

        repeat (4) @(negedge clk);
        if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
